// File: rtl/check_password.sv
// -----------------------------------------------------------------------------
// check_password
//
// Second authentication stage of the access controller. Once the ID checker
// raises IDOK, this block collects four 4-bit password digits (one per
// EnterPswd pulse), looks each one up in an external synchronous password
// ROM (address {InternalID, digit index}, one clock of read latency), and then
// grants access, reports a failed attempt, or locks the user out.
//
// Optional feature: define PSWD_LOCKOUT_EN to lock the user out on the third
// consecutive failed attempt. Without it, retries are unlimited and Locked is
// tied low.
//
// Ports:
//   Clk            in   1  system clock, rising edge
//   Reset          in   1  asynchronous, active-low reset
//   InputSwitches  in   4  current password digit
//   EnterPswd      in   1  single-cycle digit-enter pulse
//   LogOutPulse    in   1  single-cycle logout pulse
//   IDOK           in   1  level, high while the ID checker holds a valid ID
//   InternalID     in   5  user index, sampled together with EnterPswd
//   PswdRomData    in   4  ROM read data, valid one clock after the address
//   PswdRomAddr    out  7  registered ROM address {InternalID, DigitIdx}
//   PswdOK         out  1  level, high while access is granted
//   AttemptFail    out  1  one-cycle pulse per rejected 4-digit attempt
//   Locked         out  1  level, high while the user is locked out
// -----------------------------------------------------------------------------
module check_password (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [3:0] InputSwitches,
  input  logic       EnterPswd,
  input  logic       LogOutPulse,
  input  logic       IDOK,
  input  logic [4:0] InternalID,
  input  logic [3:0] PswdRomData,
  output logic [6:0] PswdRomAddr,
  output logic       PswdOK,
  output logic       AttemptFail,
  output logic       Locked
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIGIT,
    S_ROMWAIT,
    S_COMPARE,
    S_GRANTED,
    S_DENIED,
    S_LOCKED
  } state_t;

  state_t     state_q,     state_d;
  logic [1:0] digit_idx_q, digit_idx_d;
  logic [3:0] captured_q,  captured_d;
  logic       mismatch_q,  mismatch_d;
  logic [1:0] fail_cnt_q,  fail_cnt_d;
  logic [6:0] rom_addr_q,  rom_addr_d;

  // Sticky mismatch including the digit currently presented by the ROM.
  logic mismatch_now;
  assign mismatch_now = mismatch_q | (PswdRomData != captured_q);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q     <= S_IDLE;
      digit_idx_q <= 2'd0;
      captured_q  <= 4'd0;
      mismatch_q  <= 1'b0;
      fail_cnt_q  <= 2'd0;
      rom_addr_q  <= 7'd0;
    end else begin
      state_q     <= state_d;
      digit_idx_q <= digit_idx_d;
      captured_q  <= captured_d;
      mismatch_q  <= mismatch_d;
      fail_cnt_q  <= fail_cnt_d;
      rom_addr_q  <= rom_addr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    digit_idx_d = digit_idx_q;
    captured_d  = captured_q;
    mismatch_d  = mismatch_q;
    fail_cnt_d  = fail_cnt_q;
    rom_addr_d  = rom_addr_q;

    // Logout, or losing the ID while in an attempt, abandons everything.
    if (LogOutPulse || ((state_q != S_IDLE) && !IDOK)) begin
      state_d     = S_IDLE;
      digit_idx_d = 2'd0;
      captured_d  = 4'd0;
      mismatch_d  = 1'b0;
      fail_cnt_d  = 2'd0;
      rom_addr_d  = 7'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (IDOK) begin
            state_d     = S_DIGIT;
            digit_idx_d = 2'd0;
            mismatch_d  = 1'b0;
            fail_cnt_d  = 2'd0;
          end
        end
        S_DIGIT: begin
          if (EnterPswd) begin
            captured_d = InputSwitches;
            rom_addr_d = {InternalID, digit_idx_q};
            state_d    = S_ROMWAIT;
          end
        end
        // The ROM samples the address on this edge; data is valid next cycle.
        S_ROMWAIT: state_d = S_COMPARE;
        S_COMPARE: begin
          mismatch_d = mismatch_now;
          if (digit_idx_q != 2'd3) begin
            digit_idx_d = digit_idx_q + 2'd1;
            state_d     = S_DIGIT;
          end else begin
            state_d = mismatch_now ? S_DENIED : S_GRANTED;
          end
        end
        S_GRANTED: state_d = S_GRANTED;
        S_DENIED: begin
          fail_cnt_d  = (fail_cnt_q == 2'd3) ? 2'd3 : fail_cnt_q + 2'd1;
          digit_idx_d = 2'd0;
          mismatch_d  = 1'b0;
`ifdef PSWD_LOCKOUT_EN
          // Two earlier failures plus this one: lock the user out.
          state_d = (fail_cnt_q == 2'd2) ? S_LOCKED : S_DIGIT;
`else
          state_d = S_DIGIT;
`endif
        end
`ifdef PSWD_LOCKOUT_EN
        S_LOCKED: state_d = S_LOCKED;
`else
        S_LOCKED: state_d = S_IDLE;
`endif
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign PswdRomAddr = rom_addr_q;
  assign PswdOK      = (state_q == S_GRANTED);
  assign AttemptFail = (state_q == S_DENIED);
`ifdef PSWD_LOCKOUT_EN
  assign Locked      = (state_q == S_LOCKED);
`else
  assign Locked      = 1'b0;
`endif

endmodule

// File: tb/tb_check_password.sv
// -----------------------------------------------------------------------------
// tb_check_password
//
// Randomized bench for check_password. A 1-cycle-latency ROM model holds
// random passwords (user 5 = 1,2,3,4). Each 4-digit attempt is scored at the
// attempt level (digits vs. ROM image, failure count, lockout rule) and the
// expected output events (grant / fail / lock) with their cycle numbers are
// queued; a monitor pops and compares whenever the DUT raises one.
// -----------------------------------------------------------------------------
module tb_check_password;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [3:0] InputSwitches;
  logic       EnterPswd;
  logic       LogOutPulse;
  logic       IDOK;
  logic [4:0] InternalID;
  logic [3:0] PswdRomData;
  logic [6:0] PswdRomAddr;
  logic       PswdOK;
  logic       AttemptFail;
  logic       Locked;

`ifdef PSWD_LOCKOUT_EN
  localparam bit LOCKOUT = 1'b1;
`else
  localparam bit LOCKOUT = 1'b0;
`endif

  localparam int EV_GRANT = 0;
  localparam int EV_FAIL  = 1;
  localparam int EV_LOCK  = 2;

  check_password dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .InputSwitches(InputSwitches),
    .EnterPswd    (EnterPswd),
    .LogOutPulse  (LogOutPulse),
    .IDOK         (IDOK),
    .InternalID   (InternalID),
    .PswdRomData  (PswdRomData),
    .PswdRomAddr  (PswdRomAddr),
    .PswdOK       (PswdOK),
    .AttemptFail  (AttemptFail),
    .Locked       (Locked)
  );

  always #5 Clk = ~Clk;

  // Synchronous ROM, one clock of latency.
  logic [3:0] rom_img [0:127];
  always @(posedge Clk) PswdRomData <= rom_img[PswdRomAddr];

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int kind;
    int when;
  } ev_t;
  ev_t exp_q[$];

  int checks = 0;
  int errors = 0;

  // Reference model state (attempt-level).
  int m_fails;
  bit m_granted;
  bit m_locked;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, got, want, cyc);
    end else begin
      $display("check %s ok: %0h (cycle %0d)", name, got, cyc);
    end
  endtask

  task automatic observe(input int kind, input int now);
    ev_t x;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d at cycle %0d, required no event", kind, now);
    end else begin
      x = exp_q.pop_front();
      if (x.kind != kind || x.when != now) begin
        errors++;
        $display("FAIL event: got kind=%0d cycle=%0d, required kind=%0d cycle=%0d",
                 kind, now, x.kind, x.when);
      end else begin
        $display("event ok: kind=%0d cycle=%0d", kind, now);
      end
    end
  endtask

  // Monitor: detect rising PswdOK, each AttemptFail cycle, rising Locked.
  logic prev_ok = 1'b0;
  logic prev_lk = 1'b0;
  always @(negedge Clk) begin
    if (Reset === 1'b1) begin
      if (PswdOK && !prev_ok) observe(EV_GRANT, cyc);
      if (AttemptFail)        observe(EV_FAIL, cyc);
      if (Locked && !prev_lk) observe(EV_LOCK, cyc);
    end
    prev_ok <= PswdOK;
    prev_lk <= Locked;
  end

  task automatic model_clear();
    m_fails   = 0;
    m_granted = 1'b0;
    m_locked  = 1'b0;
  endtask

  // One digit press; extra=1 adds a second pulse during ROMWAIT (must be dropped).
  task automatic press(input logic [3:0] d, input logic [4:0] id, input bit extra, output int e);
    @(negedge Clk);
    InputSwitches = d;
    InternalID    = id;
    EnterPswd     = 1'b1;
    @(posedge Clk);
    #1;
    e = cyc;
    EnterPswd = 1'b0;
    if (extra) begin
      @(negedge Clk);
      EnterPswd     = 1'b1;
      InputSwitches = 4'($urandom);
      @(negedge Clk);
      EnterPswd = 1'b0;
    end else begin
      repeat (2) @(negedge Clk);
    end
  endtask

  // digits packed 4 bits each (digit 0 lowest); ids packed 5 bits each.
  // extra_mode: 0 never, 1 random, 2 always inject a ROMWAIT pulse.
  task automatic attempt(input logic [15:0] dg, input logic [19:0] ids, input int n,
                         input int extra_mode);
    int  e;
    bit  live;
    bit  mism;
    bit  ex;
    int  prior;
    logic [3:0] di;
    logic [4:0] idi;
    e    = 0;
    live = !m_granted && !m_locked;
    mism = 1'b0;
    for (int i = 0; i < n; i++) begin
      di  = dg[4*i +: 4];
      idi = ids[5*i +: 5];
      ex  = (extra_mode == 2) || (extra_mode == 1 && $urandom_range(0, 3) == 0);
      press(di, idi, ex, e);
      if (live) chk("rom_addr", 32'(PswdRomAddr), 32'({idi, 2'(i)}));
      if (di != rom_img[{idi, 2'(i)}]) mism = 1'b1;
    end
    if (n == 4) begin
      if (live) begin
        if (!mism) begin
          m_granted = 1'b1;
          exp_q.push_back(ev_t'{EV_GRANT, e + 2});
        end else begin
          prior   = m_fails;
          m_fails = (m_fails >= 3) ? 3 : m_fails + 1;
          exp_q.push_back(ev_t'{EV_FAIL, e + 2});
          if (LOCKOUT && prior == 2) begin
            m_locked = 1'b1;
            exp_q.push_back(ev_t'{EV_LOCK, e + 3});
          end
        end
      end
      repeat (2) @(negedge Clk);
      chk("pswd_ok_level", 32'(PswdOK), 32'(m_granted));
      chk("locked_level", 32'(Locked), 32'(m_locked));
    end
  endtask

  task automatic start_session(input logic [4:0] id);
    @(negedge Clk);
    IDOK       = 1'b1;
    InternalID = id;
    model_clear();
    repeat (2) @(negedge Clk);
  endtask

  task automatic logout();
    @(negedge Clk);
    LogOutPulse = 1'b1;
    @(posedge Clk);
    #1;
    chk("logout_pswd_ok", 32'(PswdOK), 32'd0);
    chk("logout_locked", 32'(Locked), 32'd0);
    LogOutPulse = 1'b0;
    model_clear();
    repeat (2) @(negedge Clk);
  endtask

  task automatic drop_idok();
    @(negedge Clk);
    IDOK = 1'b0;
    @(posedge Clk);
    #1;
    chk("abort_rom_addr", 32'(PswdRomAddr), 32'd0);
    chk("abort_pswd_ok", 32'(PswdOK), 32'd0);
    model_clear();
    @(negedge Clk);
  endtask

  initial begin
    int         e;
    logic [4:0] sid;
    logic [4:0] idi;
    logic [15:0] dg;
    logic [19:0] ids;
    bit          correct;
    bit          aborted;

    Reset         = 1'b0;
    EnterPswd     = 1'b0;
    LogOutPulse   = 1'b0;
    IDOK          = 1'b0;
    InternalID    = 5'd0;
    InputSwitches = 4'd0;
    model_clear();
    for (int a = 0; a < 128; a++) rom_img[a] = 4'($urandom);
    rom_img[20] = 4'd1;
    rom_img[21] = 4'd2;
    rom_img[22] = 4'd3;
    rom_img[23] = 4'd4;

    repeat (5) @(negedge Clk);
    chk("reset_pswd_ok", 32'(PswdOK), 32'd0);
    chk("reset_attempt_fail", 32'(AttemptFail), 32'd0);
    chk("reset_locked", 32'(Locked), 32'd0);
    chk("reset_rom_addr", 32'(PswdRomAddr), 32'd0);
    Reset = 1'b1;

    // Correct entry.
    start_session(5'd5);
    attempt(16'h4321, {4{5'd5}}, 4, 0);
    logout();
    // Wrong digit, then correct.
    attempt(16'h4221, {4{5'd5}}, 4, 0);
    attempt(16'h4321, {4{5'd5}}, 4, 0);
    logout();
    // Three failures, then a correct entry (ignored only when lockout is built in).
    attempt(16'h9999, {4{5'd5}}, 4, 0);
    attempt(16'h9999, {4{5'd5}}, 4, 0);
    attempt(16'h9999, {4{5'd5}}, 4, 0);
    attempt(16'h4321, {4{5'd5}}, 4, 0);
    logout();
    // Abort after two digits, then re-enter.
    attempt(16'h4321, {4{5'd5}}, 2, 0);
    drop_idok();
    start_session(5'd5);
    attempt(16'h4321, {4{5'd5}}, 4, 0);
    logout();
    // Extra EnterPswd during every ROMWAIT.
    attempt(16'h4321, {4{5'd5}}, 4, 2);
    logout();

    // Asynchronous reset while granted.
    attempt(16'h4321, {4{5'd5}}, 4, 0);
    #2;
    Reset = 1'b0;
    #1;
    chk("async_reset_pswd_ok", 32'(PswdOK), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    model_clear();
    repeat (2) @(negedge Clk);
    // Asynchronous reset while in COMPARE.
    press(4'd1, 5'd5, 1'b0, e);
    #2;
    Reset = 1'b0;
    #1;
    chk("async_reset_rom_addr", 32'(PswdRomAddr), 32'd0);
    chk("async_reset_fail", 32'(AttemptFail), 32'd0);
    chk("async_reset_locked", 32'(Locked), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    model_clear();
    repeat (2) @(negedge Clk);

    // Randomized sessions.
    for (int s = 0; s < 12; s++) begin
      sid = ($urandom_range(0, 2) == 0) ? 5'd5 : 5'($urandom);
      start_session(sid);
      aborted = 1'b0;
      for (int k = 0; k < 6; k++) begin
        correct = ($urandom_range(0, 2) == 0);
        for (int i = 0; i < 4; i++) begin
          idi = ($urandom_range(0, 9) == 0) ? 5'($urandom) : sid;
          ids[5*i +: 5] = idi;
          dg[4*i +: 4]  = correct ? rom_img[{idi, 2'(i)}] : 4'($urandom);
        end
        if ($urandom_range(0, 7) == 0) begin
          attempt(dg, ids, $urandom_range(1, 3), 1);
          drop_idok();
          aborted = 1'b1;
          break;
        end
        attempt(dg, ids, 4, 1);
        if (m_granted || m_locked || $urandom_range(0, 4) == 0) break;
      end
      if (!aborted) begin
        if ($urandom_range(0, 1) == 0) logout();
        else drop_idok();
      end
    end

    repeat (4) @(negedge Clk);
    chk("events_pending", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
